// File: rtl/uart_rx_frame_check.sv
// Frame-integrity checker for the UART receiver: parity and stop-bit
// verdicts per frame, plus saturating error counters for the register file.
module uart_rx_frame_check #(
  parameter int DATA_W  = 8,
  parameter int PRESC_W = 6,
  parameter int CNT_W   = 8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               frame_start,
  input  logic               PAR_EN,
  input  logic [1:0]         PAR_MODE,
  input  logic               STOP2,
  input  logic               sampled_bit,
  input  logic [PRESC_W-1:0] PRESCALE,
  input  logic [PRESC_W-1:0] edge_cnt,
  input  logic               par_chk_en,
  input  logic               stp_chk_en,
  input  logic [DATA_W-1:0]  P_data,
  input  logic               err_clr,
  output logic               par_err,
  output logic               stp_err,
  output logic               frame_valid,
  output logic               frame_err,
  output logic [CNT_W-1:0]   par_err_cnt,
  output logic [CNT_W-1:0]   stp_err_cnt,
  output logic               err_sticky
);

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    STOP2_WAIT
  } state_t;

  state_t     state, state_n;
  logic       par_en_q;
  logic [1:0] par_mode_q;
  logic       stop2_q;
  logic       stb;
  logic       exp_par;
  logic       par_n, stp_n;
  logic       done;
  logic       e;

  assign stb = (edge_cnt == PRESCALE);
  assign e   = par_n | stp_n;

  always_comb begin
    exp_par = 1'b0;
    unique case (par_mode_q)
      2'b00: exp_par = ^P_data;
      2'b01: exp_par = ~^P_data;
      2'b10: exp_par = 1'b1;
      2'b11: exp_par = 1'b0;
    endcase
  end

  // frame_start in any state (re)opens a frame; a running one is dropped
  always_comb begin
    state_n = state;
    par_n   = par_err;
    stp_n   = stp_err;
    done    = 1'b0;
    unique case (state)
      IDLE: begin
        if (frame_start) begin
          state_n = ACTIVE;
          par_n   = 1'b0;
          stp_n   = 1'b0;
        end
      end
      ACTIVE: begin
        if (frame_start) begin
          par_n = 1'b0;
          stp_n = 1'b0;
        end else if (stp_chk_en && stb) begin
          stp_n = ~sampled_bit;
          if (stop2_q) begin
            state_n = STOP2_WAIT;
          end else begin
            done    = 1'b1;
            state_n = IDLE;
          end
        end else if (par_chk_en && stb && par_en_q) begin
          par_n = (sampled_bit != exp_par);
        end
      end
      STOP2_WAIT: begin
        if (frame_start) begin
          state_n = ACTIVE;
          par_n   = 1'b0;
          stp_n   = 1'b0;
        end else if (stp_chk_en && stb) begin
          stp_n   = stp_err | ~sampled_bit;
          done    = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= IDLE;
      par_en_q    <= 1'b0;
      par_mode_q  <= 2'b00;
      stop2_q     <= 1'b0;
      par_err     <= 1'b0;
      stp_err     <= 1'b0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      state       <= state_n;
      par_err     <= par_n;
      stp_err     <= stp_n;
      frame_valid <= done & ~e;
      frame_err   <= done & e;
      if (frame_start) begin
        par_en_q   <= PAR_EN;
        par_mode_q <= PAR_MODE;
        stop2_q    <= STOP2;
      end
    end
  end

  // clear beats a same-cycle increment
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      par_err_cnt <= '0;
      stp_err_cnt <= '0;
      err_sticky  <= 1'b0;
    end else if (err_clr) begin
      par_err_cnt <= '0;
      stp_err_cnt <= '0;
      err_sticky  <= 1'b0;
    end else if (done) begin
      if (par_n && par_err_cnt != '1)
        par_err_cnt <= par_err_cnt + CNT_W'(1);
      if (stp_n && stp_err_cnt != '1)
        stp_err_cnt <= stp_err_cnt + CNT_W'(1);
      if (e)
        err_sticky <= 1'b1;
    end
  end

endmodule

// File: doc/uart_rx_frame_check.md
Name: uart_rx_frame_check

Overview:
- Parametrised frame-integrity checker for the UART receiver.
- Checks the parity bit against the deserialised word. Supports even, odd, mark and space parity, or no parity.
- Checks one or two stop bits and reports one verdict per frame.
- Keeps saturating parity-error and stop-error counters for the register file.
- Sits between the RX sampler/deserialiser and the RX FSM. The RX FSM supplies the frame_start and check enables.

Parameters:
- DATA_W, 8, data bits per frame (legal 5..9); width of P_data.
- PRESC_W, 6, width of PRESCALE and edge_cnt.
- CNT_W, 8, width of each error counter.

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous, active-low reset.
- frame_start  in  1  one-cycle pulse at start-bit detection; latches config and clears per-frame flags.
- PAR_EN  in  1  1 = frame carries a parity bit.
- PAR_MODE  in  2  00 even, 01 odd, 10 mark (bit=1), 11 space (bit=0).
- STOP2  in  1  1 = two stop bits.
- sampled_bit  in  1  majority-voted bit from the sampler.
- PRESCALE  in  PRESC_W  oversampling ratio.
- edge_cnt  in  PRESC_W  current edge count within the bit.
- par_chk_en  in  1  RX FSM is in the parity bit.
- stp_chk_en  in  1  RX FSM is in a stop bit.
- P_data  in  DATA_W  deserialised data word; stable from parity bit to end of frame.
- err_clr  in  1  synchronous clear of the counters and err_sticky.
- par_err  out  1  parity error of the current/last frame.
- stp_err  out  1  stop error of the current/last frame.
- frame_valid  out  1  one-cycle pulse: frame ended with no error.
- frame_err  out  1  one-cycle pulse: frame ended with an error.
- par_err_cnt  out  CNT_W  saturating count of parity-error frames.
- stp_err_cnt  out  CNT_W  saturating count of stop-error frames.
- err_sticky  out  1  set on any frame error; cleared only by err_clr or reset.

Behaviour:
- Reset: all outputs 0, all counters 0, FSM in IDLE, latched config 0.
- Check strobe: stb = (edge_cnt == PRESCALE). Every check is evaluated only on stb.
- Config latch: PAR_EN, PAR_MODE and STOP2 are registered on frame_start. Changes mid-frame are ignored until the next frame_start.
- Expected parity bit:
  - even = ^P_data
  - odd = ~^P_data
  - mark = 1
  - space = 0
- FSM states: IDLE, ACTIVE, STOP2_WAIT.
  - IDLE: on frame_start go to ACTIVE and clear par_err and stp_err.
  - ACTIVE, parity check: on par_chk_en && stb && latched PAR_EN, par_err <= (sampled_bit != expected). Registered, so it is visible the next cycle. Repeated strobes overwrite it.
  - ACTIVE, first stop bit: on stp_chk_en && stb, stp_err <= (sampled_bit == 0).
    - If STOP2 = 0: end the frame and go to IDLE.
    - If STOP2 = 1: go to STOP2_WAIT.
  - STOP2_WAIT: on stp_chk_en && stb, stp_err <= stp_err | (sampled_bit == 0). End the frame and go to IDLE.
- End of frame (registered, cycle after the final stop strobe):
  - Error value e = final par_err | final stp_err. This includes the current strobe's result.
  - frame_err = e, frame_valid = !e, each for exactly one cycle.
  - If e = 1, err_sticky is set.
  - par_err_cnt increments if the final par_err = 1; stp_err_cnt increments if the final stp_err = 1. Both can increment in the same cycle.
  - Counters saturate at 2^CNT_W - 1 and never wrap.
- Latched PAR_EN = 0: par_err stays 0 and parity strobes are ignored.
- par_err and stp_err hold their value after the frame until the next frame_start.
- Strobes in IDLE are ignored.
- frame_start while ACTIVE or STOP2_WAIT aborts the frame: no verdict, no counter update, flags cleared, FSM restarts in ACTIVE.
- err_clr in the same cycle as a counter increment: clear wins, so counters and err_sticky are 0 afterwards.
- par_chk_en and stp_chk_en both high: stop check takes precedence and the parity strobe is ignored.
- Reset asserted mid-frame: returns to IDLE immediately with all outputs 0; no verdict is emitted.

Test Plan:
- Even parity, 1 stop bit: PAR_MODE=00, P_data=8'hA5, parity bit 0, stop bit 1 -> frame_valid pulses once, par_err=0, counters stay 0.
- Odd parity error: PAR_MODE=01, P_data=8'h03, parity bit 0 -> par_err=1 the cycle after the parity strobe; frame_err pulses; par_err_cnt=1; err_sticky=1.
- Two stop bits, second bit 0: STOP2=1, first stop=1, second stop=0 -> no verdict after the first stop strobe; stp_err=1 and frame_err pulse after the second; stp_err_cnt=1.
- Mark/space and parity disabled: PAR_MODE=10 with parity bit 1 -> valid. PAR_MODE=11 with parity bit 1 -> par_err. PAR_EN=0 with a parity strobe present -> par_err stays 0.
- Saturation and clear: CNT_W=2, four parity-error frames -> par_err_cnt=3. Then err_clr in the same cycle as a 5th error verdict -> par_err_cnt=0, err_sticky=0.
- Abort and reset: frame_start during ACTIVE -> no verdict, counters unchanged. RST low during STOP2_WAIT -> all outputs 0, FSM in IDLE.
